// File: rtl/data_mem_pkg.sv
// Shared types and helpers for the data memory block.
package data_mem_pkg;

   localparam int unsigned MAX_READ_LATENCY = 3;

   typedef enum logic {CLEAR, RUN} state_e;

   function automatic int unsigned byte_off_bits(input int unsigned data_w);
      return $clog2(data_w / 8);
   endfunction

endpackage

// File: rtl/data_mem_if.sv
// Request/response port of the data memory: valid/ready request, pulsed in-order response.
interface data_mem_if #(
   parameter int unsigned ADDR_W = 18,
   parameter int unsigned DATA_W = 32
) ();

   logic                  req_valid;
   logic                  req_ready;
   logic                  req_we;
   logic [ADDR_W-1:0]     req_addr;
   logic [DATA_W-1:0]     req_wdata;
   logic [DATA_W/8-1:0]   req_be;
   logic                  resp_valid;
   logic [DATA_W-1:0]     resp_rdata;
   logic                  resp_err;
   logic                  init_busy;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, req_be,
      input  req_ready, resp_valid, resp_rdata, resp_err, init_busy
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, req_be,
      output req_ready, resp_valid, resp_rdata, resp_err, init_busy
   );

endinterface

// File: rtl/data_mem_array.sv
// Byte-enabled synchronous single-port word array; no reset so it maps onto block RAM.
module data_mem_array #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned WORDS  = 16,
   parameter int unsigned IDX_W  = 4
) (
   input  logic                clk,
   input  logic                we,
   input  logic [DATA_W/8-1:0] be,
   input  logic [IDX_W-1:0]    widx,
   input  logic [DATA_W-1:0]   wdata,
   output logic [DATA_W-1:0]   rdata
);

   localparam int unsigned NB = DATA_W / 8;

   logic [DATA_W-1:0] mem [WORDS];

   always_ff @(posedge clk) begin
      for (int unsigned i = 0; i < NB; i++) begin
         if (we && be[i]) mem[widx][8*i +: 8] <= wdata[8*i +: 8];
      end
      rdata <= mem[widx];
   end

endmodule

// File: rtl/data_mem.sv
// CPU data memory: clear sequencer, request/clear port mux, error check and read-latency pipeline.
module data_mem
   import data_mem_pkg::*;
#(
   parameter int unsigned ADDR_W         = 18,
   parameter int unsigned DATA_W         = 32,
   parameter int unsigned MEM_WORDS      = 2**(ADDR_W-2),
   parameter int unsigned READ_LATENCY   = 1,
   parameter bit          CLEAR_ON_RESET = 1'b1
) (
   input  logic     clk,
   input  logic     rstn,
   data_mem_if.slave bus
);

   localparam int unsigned NB       = DATA_W / 8;
   localparam int unsigned BO       = byte_off_bits(DATA_W);
   localparam int unsigned WIDX_W   = ADDR_W - BO;
   localparam int unsigned IDX_W    = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
   localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((2**BO) - 1);
   localparam state_e      RST_STATE = CLEAR_ON_RESET ? CLEAR : RUN;

   state_e             state, state_nxt;
   logic [IDX_W-1:0]   clr_cnt, clr_cnt_nxt;

   logic [WIDX_W-1:0]  widx_full;
   logic               misalign, range_err, err, accept;

   logic               arr_we;
   logic [NB-1:0]      arr_be;
   logic [IDX_W-1:0]   arr_idx;
   logic [DATA_W-1:0]  arr_wdata, arr_rdata, data_sel;

   logic [READ_LATENCY-1:0] v_pipe, e_pipe, r_pipe;

   // State register; ready/busy are registered copies of the next state
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state         <= RST_STATE;
         clr_cnt       <= '0;
         bus.req_ready <= !CLEAR_ON_RESET;
         bus.init_busy <= CLEAR_ON_RESET;
      end else begin
         state         <= state_nxt;
         clr_cnt       <= clr_cnt_nxt;
         bus.req_ready <= (state_nxt == RUN);
         bus.init_busy <= (state_nxt == CLEAR);
      end
   end

   always_comb begin
      state_nxt   = state;
      clr_cnt_nxt = clr_cnt;
      case (state)
         CLEAR: begin
            clr_cnt_nxt = clr_cnt + IDX_W'(1);
            if (clr_cnt == IDX_W'(MEM_WORDS - 1)) begin
               state_nxt   = RUN;
               clr_cnt_nxt = '0;
            end
         end
         RUN:     state_nxt = RUN;
         default: state_nxt = RST_STATE;
      endcase
   end

   assign widx_full = bus.req_addr[ADDR_W-1:BO];
   assign misalign  = |(bus.req_addr & OFF_MASK);
   assign range_err = {1'b0, widx_full} >= (WIDX_W+1)'(MEM_WORDS);
   assign err       = misalign || range_err;
   assign accept    = bus.req_valid && bus.req_ready && rstn;

   // The clear sequencer owns the array port while it runs
   always_comb begin
      arr_we    = accept && bus.req_we && !err;
      arr_be    = bus.req_be;
      arr_idx   = IDX_W'(widx_full);
      arr_wdata = bus.req_wdata;
      if (state == CLEAR) begin
         arr_we    = rstn;
         arr_be    = '1;
         arr_idx   = clr_cnt;
         arr_wdata = '0;
      end
   end

   data_mem_array #(
      .DATA_W (DATA_W),
      .WORDS  (MEM_WORDS),
      .IDX_W  (IDX_W)
   ) u_array (
      .clk   (clk),
      .we    (arr_we),
      .be    (arr_be),
      .widx  (arr_idx),
      .wdata (arr_wdata),
      .rdata (arr_rdata)
   );

   // Response control shift register; flushed by reset so in-flight responses vanish
   always_ff @(posedge clk) begin
      if (!rstn) begin
         v_pipe <= '0;
         e_pipe <= '0;
         r_pipe <= '0;
      end else begin
         v_pipe[0] <= accept;
         e_pipe[0] <= accept && err;
         r_pipe[0] <= accept && !bus.req_we;
         for (int unsigned k = 1; k < READ_LATENCY; k++) begin
            v_pipe[k] <= v_pipe[k-1];
            e_pipe[k] <= e_pipe[k-1];
            r_pipe[k] <= r_pipe[k-1];
         end
      end
   end

   if (READ_LATENCY == 1) begin : g_lat1
      assign data_sel = arr_rdata;
   end else begin : g_latn
      logic [DATA_W-1:0] dstage [READ_LATENCY-1];
      always_ff @(posedge clk) begin
         dstage[0] <= arr_rdata;
         for (int unsigned k = 1; k < READ_LATENCY - 1; k++) dstage[k] <= dstage[k-1];
      end
      assign data_sel = dstage[READ_LATENCY-2];
   end

   assign bus.resp_valid = v_pipe[READ_LATENCY-1];
   assign bus.resp_err   = e_pipe[READ_LATENCY-1];
   assign bus.resp_rdata = (v_pipe[READ_LATENCY-1] && !e_pipe[READ_LATENCY-1] && r_pipe[READ_LATENCY-1])
                           ? data_sel : '0;

endmodule

// File: tb/tb_data_mem.sv
// Bench for data_mem: two instances (read latency 1 and 3) driven in lockstep against a word-array model.
module tb_data_mem;

   localparam int unsigned AW = 8;
   localparam int unsigned DW = 32;
   localparam int unsigned MW = 16;

   logic clk = 1'b0;
   logic rstn;
   always #5 clk = ~clk;

   data_mem_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();
   data_mem_if #(.ADDR_W(AW), .DATA_W(DW)) bus3 ();

   data_mem #(.ADDR_W(AW), .DATA_W(DW), .MEM_WORDS(MW), .READ_LATENCY(1), .CLEAR_ON_RESET(1'b1))
      dut1 (.clk(clk), .rstn(rstn), .bus(bus1.slave));
   data_mem #(.ADDR_W(AW), .DATA_W(DW), .MEM_WORDS(MW), .READ_LATENCY(3), .CLEAR_ON_RESET(1'b1))
      dut3 (.clk(clk), .rstn(rstn), .bus(bus3.slave));

   logic [31:0] mem_m [MW];
   int          clr_left;
   bit          known;
   int          cyc;
   logic        exp_v [2][16];
   logic        exp_e [2][16];
   logic [31:0] exp_d [2][16];
   int          vectors;
   int          miscompares;

   task automatic chk1(input string tag, input logic obs, input logic exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s cyc=%0d: observed %b expected %b", tag, cyc, obs, exp);
      end
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s cyc=%0d: observed %h expected %h", tag, cyc, obs, exp);
      end
   endtask

   task automatic clear_slots();
      for (int li = 0; li < 2; li++)
         for (int s = 0; s < 16; s++) begin
            exp_v[li][s] = 1'b0;
            exp_e[li][s] = 1'b0;
            exp_d[li][s] = '0;
         end
   endtask

   // One clock cycle: present a request, advance the model across the edge, then check both DUTs
   task automatic drive(input bit v, input bit we, input logic [7:0] a,
                        input logic [31:0] d, input logic [3:0] be);
      bit          err;
      int          w;
      logic [31:0] rd;
      bus1.req_valid = v;  bus1.req_we = we;  bus1.req_addr = a;
      bus1.req_wdata = d;  bus1.req_be = be;
      bus3.req_valid = v;  bus3.req_we = we;  bus3.req_addr = a;
      bus3.req_wdata = d;  bus3.req_be = be;

      if (!rstn) begin
         known    = 1'b1;
         clr_left = int'(MW);
         for (int i = 0; i < int'(MW); i++) mem_m[i] = '0;
         clear_slots();
      end else if (known && clr_left > 0) begin
         clr_left--;
      end else if (known && v) begin
         w   = int'(a) / 4;
         err = (a % 4 != 0) || (w >= int'(MW));
         rd  = '0;
         if (!err) begin
            if (we) begin
               for (int b = 0; b < 4; b++)
                  if (be[b]) mem_m[w][8*b +: 8] = d[8*b +: 8];
            end else begin
               rd = mem_m[w];
            end
         end
         for (int li = 0; li < 2; li++) begin
            int s;
            s = (cyc + ((li == 0) ? 1 : 3)) % 16;
            exp_v[li][s] = 1'b1;
            exp_e[li][s] = err;
            exp_d[li][s] = rd;
         end
      end

      @(posedge clk);
      #1;
      cyc++;

      if (known) begin
         int s;
         s = cyc % 16;
         chk1("ready1", bus1.req_ready, clr_left == 0);
         chk1("busy1",  bus1.init_busy, clr_left != 0);
         chk1("ready3", bus3.req_ready, clr_left == 0);
         chk1("busy3",  bus3.init_busy, clr_left != 0);
         chk1 ("valid1", bus1.resp_valid, exp_v[0][s]);
         chk1 ("err1",   bus1.resp_err,   exp_e[0][s]);
         chk32("rdata1", bus1.resp_rdata, exp_d[0][s]);
         chk1 ("valid3", bus3.resp_valid, exp_v[1][s]);
         chk1 ("err3",   bus3.resp_err,   exp_e[1][s]);
         chk32("rdata3", bus3.resp_rdata, exp_d[1][s]);
         for (int li = 0; li < 2; li++) begin
            exp_v[li][s] = 1'b0;
            exp_e[li][s] = 1'b0;
            exp_d[li][s] = '0;
         end
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
   endtask

   task automatic rd(input logic [7:0] a);
      drive(1'b1, 1'b0, a, 32'h0, 4'h0);
   endtask

   task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
      drive(1'b1, 1'b1, a, d, be);
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      cyc         = 0;
      known       = 1'b0;
      clr_left    = 0;
      clear_slots();
      rstn        = 1'b0;

      // Reset then full clear; ready rises after exactly MW busy cycles
      idle(2);
      rstn = 1'b1;
      idle(int'(MW));
      rd(8'h14);
      idle(4);

      // Full-word write, partial byte write, readback
      wr(8'h10, 32'hDEADBEEF, 4'hF);
      wr(8'h10, 32'h000000AA, 4'h1);
      rd(8'h10);
      idle(4);

      // Back-to-back reads, strictly in order
      wr(8'h00, 32'h11111111, 4'hF);
      wr(8'h04, 32'h22222222, 4'hF);
      wr(8'h08, 32'h33333333, 4'hF);
      rd(8'h00);
      rd(8'h04);
      rd(8'h08);
      idle(4);

      // Misaligned read, out-of-range write, then full readback; be=0 write
      rd(8'h12);
      wr(8'h40, 32'hCAFEF00D, 4'hF);
      wr(8'h0C, 32'h55555555, 4'h0);
      for (int w = 0; w < int'(MW); w++) rd(8'(w * 4));
      idle(4);

      // Write followed immediately by a read of the same word
      wr(8'h20, 32'h00001234, 4'hF);
      rd(8'h20);
      idle(4);

      // Random traffic
      for (int i = 0; i < 200; i++) begin
         logic [7:0] a;
         if ($urandom_range(0, 3) == 0) a = 8'($urandom());
         else                           a = 8'($urandom_range(0, 15) << 2);
         drive($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), a, $urandom(), 4'($urandom()));
      end
      idle(4);

      // Reset partway through the clear restarts it from word 0
      rstn = 1'b0;
      idle(1);
      rstn = 1'b1;
      idle(7);
      rstn = 1'b0;
      idle(1);
      rstn = 1'b1;
      idle(int'(MW));

      // Reset with reads in flight: nothing may emerge afterwards
      wr(8'h18, 32'h0BADBEEF, 4'hF);
      rd(8'h18);
      rd(8'h10);
      rstn = 1'b0;
      idle(1);
      rstn = 1'b1;
      idle(int'(MW));
      rd(8'h18);
      rd(8'h10);
      idle(4);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
